// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin scheduler sharing one combinational ALU between two requesters
module alu_rr_sched #(
    parameter int DATA_W  = 8,
    parameter int CTRL_W  = 4,
    parameter int ERR_MIN = 13,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_out,
    output logic              resp_carry,
    output logic              resp_err,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic [CNT_W-1:0]  op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   id_q;
    logic   grant;
    logic   accept;

    // A lone requester always wins; prio only breaks ties.
    always_comb begin
        grant = prio;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) && grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            id_q       <= 1'b0;
            alu_ctrl   <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_out   <= '0;
            resp_carry <= 1'b0;
            resp_err   <= 1'b0;
            op_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // alu_* only load on accept so the ALU inputs stay quiet while idle
                    if (accept) begin
                        alu_ctrl <= grant ? req1_ctrl : req0_ctrl;
                        alu_x    <= grant ? req1_x : req0_x;
                        alu_y    <= grant ? req1_y : req0_y;
                        id_q     <= grant;
                        prio     <= ~grant;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    resp_out   <= alu_out;
                    resp_carry <= alu_carry;
                    resp_err   <= (alu_ctrl >= CTRL_W'(ERR_MIN));
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (op_cnt != {CNT_W{1'b1}}) begin
                            op_cnt <= op_cnt + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - self-checking bench for alu_rr_sched with a transaction-level reference model
module tb_alu_rr_sched;

    localparam int DATA_W  = 8;
    localparam int CTRL_W  = 4;
    localparam int ERR_MIN = 13;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl, alu_ctrl;
    logic [DATA_W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic              resp_valid, resp_ready, resp_id, resp_carry, resp_err;
    logic [DATA_W-1:0] resp_out, alu_x, alu_y, alu_out;
    logic              alu_carry;
    logic [CNT_W-1:0]  op_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_rr_sched #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .ERR_MIN(ERR_MIN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_ctrl (req0_ctrl),
        .req0_x    (req0_x),
        .req0_y    (req0_y),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_ctrl (req1_ctrl),
        .req1_x    (req1_x),
        .req1_y    (req1_y),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_out  (resp_out),
        .resp_carry(resp_carry),
        .resp_err  (resp_err),
        .alu_ctrl  (alu_ctrl),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .op_cnt    (op_cnt)
    );

    // Reference ALU: carry only for add/sub, illegal opcodes give 0/0.
    function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        case (c)
            4'd0:    return {1'b0, x} + {1'b0, y};
            4'd1:    return {1'b0, x} - {1'b0, y};
            4'd2:    return {1'b0, x & y};
            4'd3:    return {1'b0, x | y};
            4'd4:    return {1'b0, x ^ y};
            4'd5:    return {1'b0, ~x};
            4'd6:    return {1'b0, y >> x[2:0]};
            4'd7:    return {1'b0, y << x[2:0]};
            4'd8:    return {1'b0, x};
            4'd9:    return {1'b0, y};
            4'd10:   return {1'b0, ~y};
            4'd11:   return {1'b0, x >> 1};
            4'd12:   return {1'b0, x << 1};
            default: return 9'd0;
        endcase
    endfunction

    assign {alu_carry, alu_out} = alu_f(alu_ctrl, alu_x, alu_y);

    // Expected response packed as {id, err, carry, out}.
    function automatic logic [10:0] exp_resp(input logic id, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        return {id, (c >= 4'(ERR_MIN)), alu_f(c, x, y)};
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_ctrl = '0; req0_x = '0; req0_y = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_x = '0; req1_y = '0;
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) drive_edge();
        rst_n = 1'b1;
    endtask

    // Issue one op, wait for its response with resp_ready high; lat counts cycles from accept to resp_valid.
    task automatic run_op(input logic id, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                          output logic ok, output logic [10:0] r, output int lat);
        logic acc;
        ok = 1'b0; r = '0; lat = 0; acc = 1'b0; resp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_ctrl = c; req1_x = x; req1_y = y;
        end else begin
            req0_valid = 1'b1; req0_ctrl = c; req0_x = x; req0_y = y;
        end
        for (int i = 0; i < 10 && !acc; i++) begin
            sample();
            acc = id ? req1_ready : req0_ready;
            drive_edge();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (acc) begin
            for (int i = 1; i <= 10 && !ok; i++) begin
                sample();
                if (resp_valid) begin
                    ok = 1'b1; lat = i;
                    r = {resp_id, resp_err, resp_carry, resp_out};
                end
                drive_edge();
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        drive_edge();
        sample();
        vectors++;
        if ({resp_valid, req0_ready, req1_ready} !== 3'b000) begin
            miscompares++; $display("FAIL reset_handshake got %b want 000", {resp_valid, req0_ready, req1_ready});
        end
        vectors++;
        if ({resp_id, resp_err, resp_carry, resp_out} !== 11'h0) begin
            miscompares++; $display("FAIL reset_resp got %h want 000", {resp_id, resp_err, resp_carry, resp_out});
        end
        vectors++;
        if ({alu_ctrl, alu_x, alu_y} !== 20'h0) begin
            miscompares++; $display("FAIL reset_alu got %h want 00000", {alu_ctrl, alu_x, alu_y});
        end
        vectors++;
        if (op_cnt !== '0) begin
            miscompares++; $display("FAIL reset_op_cnt got %0d want 0", op_cnt);
        end
        drive_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic ok; logic [10:0] r; int lat;
        do_reset();
        run_op(1'b0, 4'd0, 8'h80, 8'h80, ok, r, lat);
        vectors++;
        if (!ok || lat != 2) begin
            miscompares++; $display("FAIL basic_latency got ok=%0b lat=%0d want ok=1 lat=2", ok, lat);
        end
        vectors++;
        if (r !== 11'b0_0_1_00000000) begin
            miscompares++; $display("FAIL basic_resp got %h want %h", r, 11'b0_0_1_00000000);
        end
        sample();
        vectors++;
        if (op_cnt !== CNT_W'(1) || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_op_cnt got cnt=%0d rv=%0b want cnt=1 rv=0", op_cnt, resp_valid);
        end
        drive_edge();
    endtask

    task automatic test_fairness();
        logic [10:0] expq[$];
        logic        gseq[$];
        int          nresp;
        logic        a0, a1;
        idle_inputs();
        req0_valid = 1'b1; req0_ctrl = 4'd3; req0_x = 8'h01; req0_y = 8'($urandom);
        req1_valid = 1'b1; req1_ctrl = 4'd3; req1_x = 8'h02; req1_y = 8'($urandom);
        resp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) drive_edge();
        rst_n = 1'b1;
        nresp = 0;
        for (int cyc = 0; cyc < 80 && nresp < 8; cyc++) begin
            sample();
            a0 = req0_ready;
            a1 = req1_ready;
            if (resp_valid) begin
                vectors++;
                if (expq.size() == 0 || {resp_id, resp_err, resp_carry, resp_out} !== expq[0]) begin
                    miscompares++;
                    $display("FAIL fair_resp got %h want %h", {resp_id, resp_err, resp_carry, resp_out},
                             (expq.size() != 0) ? expq[0] : 11'h0);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                nresp++;
            end
            if (a0) begin gseq.push_back(1'b0); expq.push_back(exp_resp(1'b0, req0_ctrl, req0_x, req0_y)); end
            if (a1) begin gseq.push_back(1'b1); expq.push_back(exp_resp(1'b1, req1_ctrl, req1_x, req1_y)); end
            drive_edge();
            if (a0) begin
                req0_x = req0_x + 8'h10; req0_y = 8'($urandom);
                if (gseq.size() >= 8) req0_valid = 1'b0;
            end
            if (a1) begin
                req1_x = req1_x + 8'h10; req1_y = 8'($urandom);
                if (gseq.size() >= 8) req1_valid = 1'b0;
            end
            if (gseq.size() >= 8) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        vectors++;
        if (nresp != 8 || gseq.size() != 8) begin
            miscompares++; $display("FAIL fair_count got resp=%0d grants=%0d want 8/8", nresp, gseq.size());
        end
        for (int i = 0; i < gseq.size(); i++) begin
            vectors++;
            if (gseq[i] !== ((i % 2) == 1)) begin
                miscompares++; $display("FAIL fair_order grant %0d got %0b want %0b", i, gseq[i], ((i % 2) == 1));
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [10:0] r;
        logic        seen;
        do_reset();
        req1_valid = 1'b1; req1_ctrl = 4'd7; req1_x = 8'h03; req1_y = 8'h11;
        resp_ready = 1'b0;
        sample();
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++; $display("FAIL bp_accept got %b want 01", {req0_ready, req1_ready});
        end
        drive_edge();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 4'd2; req0_x = 8'hF0; req0_y = 8'h3C;
        sample();
        vectors++;
        if (req0_ready !== 1'b0 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_exec got ready=%0b rv=%0b want 0 0", req0_ready, resp_valid);
        end
        drive_edge();
        for (int i = 0; i < 5; i++) begin
            sample();
            r = {resp_id, resp_err, resp_carry, resp_out};
            vectors++;
            if (resp_valid !== 1'b1 || r !== 11'b1_0_0_10001000 || req0_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got rv=%0b resp=%h ready0=%0b want 1 488 0", i, resp_valid, r, req0_ready);
            end
            drive_edge();
        end
        resp_ready = 1'b1;
        sample();
        drive_edge();
        sample();
        vectors++;
        if (op_cnt !== CNT_W'(1) || resp_valid !== 1'b0 || req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got cnt=%0d rv=%0b ready0=%0b want 1 0 1", op_cnt, resp_valid, req0_ready);
        end
        drive_edge();
        req0_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            sample();
            if (resp_valid) begin
                seen = 1'b1;
                vectors++;
                if ({resp_id, resp_err, resp_carry, resp_out} !== exp_resp(1'b0, 4'd2, 8'hF0, 8'h3C)) begin
                    miscompares++; $display("FAIL bp_second got %h want %h", {resp_id, resp_err, resp_carry, resp_out},
                                            exp_resp(1'b0, 4'd2, 8'hF0, 8'h3C));
                end
            end
            drive_edge();
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL bp_second_timeout got no response want one");
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  cl[4] = '{4'hD, 4'hC, 4'hF, 4'h1};
        logic        ok; logic [10:0] r; int lat;
        logic [7:0]  x, y;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            x = (i == 0) ? 8'h55 : 8'($urandom);
            y = (i == 0) ? 8'hAA : 8'($urandom);
            run_op(i[0], cl[i], x, y, ok, r, lat);
            vectors++;
            if (!ok || lat != 2 || r !== exp_resp(i[0], cl[i], x, y)) begin
                miscompares++;
                $display("FAIL illegal_op ctrl=%h got ok=%0b lat=%0d resp=%h want %h", cl[i], ok, lat, r, exp_resp(i[0], cl[i], x, y));
            end
            sample();
            vectors++;
            if (op_cnt !== CNT_W'(i + 1)) begin
                miscompares++; $display("FAIL illegal_op_cnt got %0d want %0d", op_cnt, i + 1);
            end
            drive_edge();
        end
    endtask

    task automatic test_reset_mid();
        logic ok; logic [10:0] r; int lat;
        logic seen;
        do_reset();
        run_op(1'b0, 4'd0, 8'h01, 8'h02, ok, r, lat);
        req1_valid = 1'b1; req1_ctrl = 4'd0; req1_x = 8'h33; req1_y = 8'h44; resp_ready = 1'b1;
        sample();
        drive_edge();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        sample();
        drive_edge();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (resp_valid) seen = 1'b1;
            drive_edge();
        end
        sample();
        vectors++;
        if (seen || op_cnt !== '0 || {alu_ctrl, alu_x, alu_y} !== 20'h0) begin
            miscompares++;
            $display("FAIL rst_exec got seen=%0b cnt=%0d alu=%h want 0 0 00000", seen, op_cnt, {alu_ctrl, alu_x, alu_y});
        end
        drive_edge();
        run_op(1'b1, 4'd1, 8'h10, 8'h20, ok, r, lat);
        vectors++;
        if (!ok || lat != 2 || r !== exp_resp(1'b1, 4'd1, 8'h10, 8'h20)) begin
            miscompares++;
            $display("FAIL rst_next_op got ok=%0b lat=%0d resp=%h want %h", ok, lat, r, exp_resp(1'b1, 4'd1, 8'h10, 8'h20));
        end
        req0_valid = 1'b1; req0_ctrl = 4'd4; req0_x = 8'h0F; req0_y = 8'hFF; resp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            sample();
            seen = resp_valid;
            drive_edge();
            req0_valid = 1'b0;
        end
        rst_n = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        sample();
        vectors++;
        if (!seen || resp_valid !== 1'b0 || op_cnt !== '0) begin
            miscompares++; $display("FAIL rst_resp got reached=%0b rv=%0b cnt=%0d want 1 0 0", seen, resp_valid, op_cnt);
        end
        drive_edge();
    endtask

    task automatic test_saturate();
        logic [10:0] expq[$];
        int          accepts, done, last, exp_cnt;
        logic        a0;
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'($urandom_range(0, 15)); req0_x = 8'($urandom); req0_y = 8'($urandom);
        accepts = 0; done = 0; last = 0;
        for (int cyc = 0; cyc < 120 && done < 17; cyc++) begin
            sample();
            exp_cnt = (done > 15) ? 15 : done;
            vectors++;
            if (op_cnt !== CNT_W'(exp_cnt)) begin
                miscompares++; $display("FAIL sat_cnt got %0d want %0d", op_cnt, exp_cnt);
            end
            a0 = req0_ready;
            if (resp_valid) begin
                vectors++;
                if (expq.size() == 0 || {resp_id, resp_err, resp_carry, resp_out} !== expq[0]) begin
                    miscompares++;
                    $display("FAIL sat_resp got %h want %h", {resp_id, resp_err, resp_carry, resp_out},
                             (expq.size() != 0) ? expq[0] : 11'h0);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                done++;
            end
            if (a0) begin
                accepts++;
                if (accepts > 1) begin
                    vectors++;
                    if (cyc - last != 3) begin
                        miscompares++; $display("FAIL sat_spacing got %0d want 3", cyc - last);
                    end
                end
                last = cyc;
                expq.push_back(exp_resp(1'b0, req0_ctrl, req0_x, req0_y));
            end
            drive_edge();
            if (a0) begin
                if (accepts == 17) req0_valid = 1'b0;
                else begin
                    req0_ctrl = 4'($urandom_range(0, 15)); req0_x = 8'($urandom); req0_y = 8'($urandom);
                end
            end
        end
        sample();
        vectors++;
        if (done != 17 || accepts != 17 || op_cnt !== CNT_W'(15)) begin
            miscompares++; $display("FAIL sat_final got done=%0d acc=%0d cnt=%0d want 17 17 15", done, accepts, op_cnt);
        end
        drive_edge();
    endtask

    task automatic test_random();
        logic        mprio, busy, e0, e1, exp_rv;
        int          age, mcnt;
        logic [10:0] expv;
        do_reset();
        mprio = 1'b0; busy = 1'b0; age = 0; mcnt = 0; expv = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_ctrl = 4'($urandom_range(0, 15)); req0_x = 8'($urandom); req0_y = 8'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_ctrl = 4'($urandom_range(0, 15)); req1_x = 8'($urandom); req1_y = 8'($urandom);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            sample();
            if (busy) age++;
            e0 = !busy && req0_valid && (!req1_valid || !mprio);
            e1 = !busy && req1_valid && (!req0_valid || mprio);
            exp_rv = busy && (age >= 2);
            vectors++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                miscompares++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, {req0_ready, req1_ready}, {e0, e1});
            end
            vectors++;
            if (resp_valid !== exp_rv) begin
                miscompares++; $display("FAIL rnd_resp_valid cyc %0d got %0b want %0b", cyc, resp_valid, exp_rv);
            end
            if (exp_rv) begin
                vectors++;
                if ({resp_id, resp_err, resp_carry, resp_out} !== expv) begin
                    miscompares++; $display("FAIL rnd_resp cyc %0d got %h want %h", cyc, {resp_id, resp_err, resp_carry, resp_out}, expv);
                end
            end
            vectors++;
            if (op_cnt !== CNT_W'(mcnt)) begin
                miscompares++; $display("FAIL rnd_op_cnt cyc %0d got %0d want %0d", cyc, op_cnt, mcnt);
            end
            if (exp_rv && resp_ready) begin
                busy = 1'b0;
                if (mcnt < 15) mcnt++;
            end else if (e0 || e1) begin
                busy = 1'b1; age = 0;
                expv = e1 ? exp_resp(1'b1, req1_ctrl, req1_x, req1_y) : exp_resp(1'b0, req0_ctrl, req0_x, req0_y);
                mprio = e0;
            end
            drive_edge();
            if (e0) req0_valid = 1'b0;
            if (e1) req1_valid = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_fairness();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
